// File: rtl/dyt_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : dyt_regfile_sb
// Description : Parametrised 2W/2R flop-based register file with a per-register
//               busy scoreboard. Define DYT_RF_BYPASS_EN to forward same-cycle
//               writeback data (and busy clear) onto the read ports.
// Revision    : 1.0 - initial release
// ============================================================================
module dyt_regfile_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w0_en,
    input  logic [ADDR_WIDTH-1:0] w0_addr,
    input  logic [DATA_WIDTH-1:0] w0_data,
    input  logic                  w1_en,
    input  logic [ADDR_WIDTH-1:0] w1_addr,
    input  logic [DATA_WIDTH-1:0] w1_data,
    input  logic                  iss_en,
    input  logic [ADDR_WIDTH-1:0] iss_addr,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] r_a_addr,
    output logic [DATA_WIDTH-1:0] r_a_data,
    output logic                  r_a_busy,
    input  logic [ADDR_WIDTH-1:0] r_b_addr,
    output logic [DATA_WIDTH-1:0] r_b_data,
    output logic                  r_b_busy
);

    localparam int NUM_WORDS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_WORDS];
    logic [NUM_WORDS-1:0]  busy;
    logic [NUM_WORDS-1:0]  busy_nxt;

    // Priority per register: flush, then issue (new producer), then writeback clear.
    always_comb begin
        busy_nxt = busy;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (flush) begin
                busy_nxt[i] = 1'b0;
            end else if (iss_en && iss_addr == ADDR_WIDTH'(i)) begin
                busy_nxt[i] = 1'b1;
            end else if ((w0_en && w0_addr == ADDR_WIDTH'(i)) ||
                         (w1_en && w1_addr == ADDR_WIDTH'(i))) begin
                busy_nxt[i] = 1'b0;
            end
        end
        if (ZERO_REG != 0) begin
            busy_nxt[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                if (!(ZERO_REG != 0 && i == 0)) begin
                    if (w1_en && w1_addr == ADDR_WIDTH'(i)) begin
                        regs[i] <= w1_data;
                    end else if (w0_en && w0_addr == ADDR_WIDTH'(i)) begin
                        regs[i] <= w0_data;
                    end
                end
            end
            busy <= busy_nxt;
        end
    end

    // Returns {busy, data} for one read address.
    function automatic logic [DATA_WIDTH:0] read_port(input logic [ADDR_WIDTH-1:0] addr);
        logic [DATA_WIDTH-1:0] d;
        logic                  b;
        d = regs[addr];
        b = busy[addr];
`ifdef DYT_RF_BYPASS_EN
        // Forwarding is suppressed in reset so reads stay zero until release.
        if (rst) begin
            if (w1_en && w1_addr == addr) begin
                d = w1_data;
                b = iss_en && iss_addr == addr;
            end else if (w0_en && w0_addr == addr) begin
                d = w0_data;
                b = iss_en && iss_addr == addr;
            end
        end
`endif
        if (ZERO_REG != 0 && addr == '0) begin
            d = '0;
            b = 1'b0;
        end
        return {b, d};
    endfunction

    always_comb begin
        {r_a_busy, r_a_data} = read_port(r_a_addr);
        {r_b_busy, r_b_data} = read_port(r_b_addr);
    end

endmodule
`default_nettype wire

// File: tb/tb_dyt_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_dyt_regfile_sb
// Description : Scoreboard bench for dyt_regfile_sb (64-bit x 16 build).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dyt_regfile_sb;

    localparam int DW = 64;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          w0_en, w1_en, iss_en, flush;
    logic [AW-1:0] w0_addr, w1_addr, iss_addr, r_a_addr, r_b_addr;
    logic [DW-1:0] w0_data, w1_data, r_a_data, r_b_data;
    logic          r_a_busy, r_b_busy;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        string         name;
        logic          port;   // 0 = A, 1 = B
        logic [DW-1:0] data;
        logic          busy;
    } exp_t;

    exp_t exp_q[$];

    dyt_regfile_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst),
        .w0_en(w0_en), .w0_addr(w0_addr), .w0_data(w0_data),
        .w1_en(w1_en), .w1_addr(w1_addr), .w1_data(w1_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush),
        .r_a_addr(r_a_addr), .r_a_data(r_a_data), .r_a_busy(r_a_busy),
        .r_b_addr(r_b_addr), .r_b_data(r_b_data), .r_b_busy(r_b_busy)
    );

    always #5 clk = ~clk;

    // Monitor: read ports are sampled mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            logic [DW-1:0] d;
            logic b;
            e = exp_q.pop_front();
            d = e.port ? r_b_data : r_a_data;
            b = e.port ? r_b_busy : r_a_busy;
            tests++;
            if (d !== e.data || b !== e.busy) begin
                failed++;
                $display("FAIL %s: got data=%h busy=%b, expected data=%h busy=%b",
                         e.name, d, b, e.data, e.busy);
            end
        end
    end

    task automatic expect_rd(input string name, input logic port,
                             input logic [DW-1:0] data, input logic busy);
        exp_t e;
        e.name = name; e.port = port; e.data = data; e.busy = busy;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        w0_en = 1'b0; w1_en = 1'b0; iss_en = 1'b0; flush = 1'b0;
    endtask

    function automatic logic [DW-1:0] pat(input int i);
        return {32'hA5A5_0000 + 32'(i), 32'h0F0F_0000 ^ (32'(i) << 8)};
    endfunction

    initial begin
        rst = 1'b0;
        idle();
        w0_addr = '0; w1_addr = '0; iss_addr = '0; r_a_addr = '0; r_b_addr = '0;
        w0_data = '0; w1_data = '0;
        #2;
        expect_rd("reset_a", 1'b0, '0, 1'b0);
        expect_rd("reset_b", 1'b1, '0, 1'b0);
        step();
        rst = 1'b1;

        // Test 1: async reset mid-operation
        w0_en = 1'b1; w0_addr = 4'd5; w0_data = 64'hDEADBEEF;
        iss_en = 1'b1; iss_addr = 4'd5;
        step();
        idle(); r_a_addr = 4'd5;
        expect_rd("x5_written_busy", 1'b0, 64'hDEADBEEF, 1'b1);
        step();
        rst = 1'b0;
        expect_rd("x5_async_reset", 1'b0, '0, 1'b0);
        step();
        rst = 1'b1;

        // Test 2: zero register ignores writes and issue
        w0_en = 1'b1; w0_addr = 4'd0; w0_data = '1;
        iss_en = 1'b1; iss_addr = 4'd0; r_a_addr = 4'd0;
        expect_rd("x0_same_cycle", 1'b0, '0, 1'b0);
        step();
        idle();
        expect_rd("x0_after", 1'b0, '0, 1'b0);
        step();
        expect_rd("x0_later", 1'b0, '0, 1'b0);

        // Test 3: write collision, w1 wins
        w0_en = 1'b1; w0_addr = 4'd7; w0_data = 64'h11;
        w1_en = 1'b1; w1_addr = 4'd7; w1_data = 64'h22;
        r_b_addr = 4'd7;
`ifdef DYT_RF_BYPASS_EN
        expect_rd("x7_collide_bypass", 1'b1, 64'h22, 1'b0);
`else
        expect_rd("x7_collide_old", 1'b1, '0, 1'b0);
`endif
        step();
        idle();
        expect_rd("x7_collide", 1'b1, 64'h22, 1'b0);
        step();

        // Test 4: issue and writeback race, then flush over issue
        iss_en = 1'b1; iss_addr = 4'd3;
        step();
        idle(); r_a_addr = 4'd3;
        expect_rd("x3_busy", 1'b0, '0, 1'b1);
        step();
        iss_en = 1'b1; iss_addr = 4'd3;
        w1_en = 1'b1; w1_addr = 4'd3; w1_data = 64'h55;
`ifdef DYT_RF_BYPASS_EN
        expect_rd("x3_race_bypass", 1'b0, 64'h55, 1'b1);
`else
        expect_rd("x3_race_old", 1'b0, '0, 1'b1);
`endif
        step();
        idle();
        expect_rd("x3_race_set_wins", 1'b0, 64'h55, 1'b1);
        flush = 1'b1; iss_en = 1'b1; iss_addr = 4'd9; r_b_addr = 4'd9;
        step();
        idle();
        expect_rd("x3_flushed", 1'b0, 64'h55, 1'b0);
        expect_rd("x9_flush_over_iss", 1'b1, '0, 1'b0);
        step();

        // Test 5: bypass of same-cycle writeback
        iss_en = 1'b1; iss_addr = 4'd4;
        step();
        idle(); r_a_addr = 4'd4;
        w0_en = 1'b1; w0_addr = 4'd4; w0_data = 64'hCAFE;
`ifdef DYT_RF_BYPASS_EN
        expect_rd("x4_bypass", 1'b0, 64'hCAFE, 1'b0);
`else
        expect_rd("x4_no_bypass", 1'b0, '0, 1'b1);
`endif
        step();
        idle();
        expect_rd("x4_after", 1'b0, 64'hCAFE, 1'b0);
        step();

        // Test 6: full-width word on both ports, then all registers independent
        w0_en = 1'b1; w0_addr = 4'd15; w0_data = 64'h0123456789ABCDEF;
        step();
        idle(); r_a_addr = 4'd15; r_b_addr = 4'd15;
        expect_rd("x15_a", 1'b0, 64'h0123456789ABCDEF, 1'b0);
        expect_rd("x15_b", 1'b1, 64'h0123456789ABCDEF, 1'b0);
        step();
        for (int i = 0; i < 16; i += 2) begin
            w0_en = 1'b1; w0_addr = AW'(i);     w0_data = pat(i);
            w1_en = 1'b1; w1_addr = AW'(i + 1); w1_data = pat(i + 1);
            step();
        end
        idle();
        for (int i = 0; i < 16; i++) begin
            r_a_addr = AW'(i);
            r_b_addr = AW'(15 - i);
            expect_rd($sformatf("all_a_x%0d", i), 1'b0, (i == 0) ? '0 : pat(i), 1'b0);
            expect_rd($sformatf("all_b_x%0d", 15 - i), 1'b1, (i == 15) ? '0 : pat(15 - i), 1'b0);
            step();
        end

        step();
        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL queue_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
